// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared state encodings and default widths for the frame capture path
package osc_pkg;

  localparam int OSC_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_STREAM    = 2'd2,
    ST_DONE      = 2'd3
  } osc_state_e;

endpackage

// File: rtl/edge_trigger.sv
// rtl/edge_trigger.sv - rising level-crossing detector over the popped sample stream
module edge_trigger
  import osc_pkg::*;
#(
  parameter int DATA_WIDTH = OSC_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  sample_vld_i,
  input  logic                  trig_en_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  output logic                  fire_o
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_valid_q;
  logic                  crossed;

  // Remember the last popped sample; the history is forgotten whenever the controller idles
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (sample_vld_i) begin
      prev_q       <= sample_i;
      prev_valid_q <= 1'b1;
    end
  end

  // Free-run fires on any popped sample; level mode needs a below-to-at-or-above step
  always_comb begin
    crossed = prev_valid_q && (prev_q < level_i) && (sample_i >= level_i);
    fire_o  = sample_vld_i && (!trig_en_i || crossed);
  end

endmodule

// File: rtl/frame_read_ctrl.sv
// rtl/frame_read_ctrl.sv - pops a FIFO, waits for a trigger, streams one fixed-length frame
module frame_read_ctrl
  import osc_pkg::*;
#(
  parameter int DATA_WIDTH = OSC_DATA_WIDTH,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  trig_en_i,
  input  logic [DATA_WIDTH-1:0] trig_level_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_inc_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  osc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pop;
  logic                  wait_pop;
  logic                  fire;
  logic                  accept_last;

  // Every available word is drained while hunting for the trigger
  assign wait_pop = rst_i && !abort_i && (state_q == ST_WAIT_TRIG) && !fifo_empty_i;
  assign accept_last = out_valid_q && out_ready_i && out_last_q;

  edge_trigger #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_edge_trigger (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (state_q == ST_IDLE),
    .sample_vld_i(wait_pop),
    .trig_en_i   (trig_en_i),
    .sample_i    (fifo_data_i),
    .level_i     (trig_level_i),
    .fire_o      (fire)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything else
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (arm_i) state_d = ST_WAIT_TRIG;
        ST_WAIT_TRIG: if (fire) state_d = ST_STREAM;
        ST_STREAM:    if (accept_last) state_d = ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Pop strobe and next values of the registered outputs
  always_comb begin
    pop         = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (abort_i) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
        ST_WAIT_TRIG: begin
          pop = wait_pop;
          if (fire) begin
            out_data_d  = fifo_data_i;
            out_valid_d = 1'b1;
            cnt_d       = CNT_ONE;
          end
        end
        ST_STREAM: begin
          // Pop only when the output slot is free or being emptied this cycle
          pop = !fifo_empty_i && (cnt_q < CNT_MAX) && (!out_valid_q || out_ready_i);
          if (pop) begin
            out_data_d  = fifo_data_i;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + CNT_ONE;
          end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end
    if (!rst_i) begin
      pop = 1'b0;
    end
    out_last_d = out_valid_d && (cnt_d == CNT_MAX);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // Output and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fifo_inc_o  = pop;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// tb/tb_frame_read_ctrl.sv - directed self-checking bench for frame_read_ctrl
module tb_frame_read_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       arm1 = 1'b0;
  logic       abort = 1'b0;
  logic       trig_en = 1'b0;
  logic [7:0] level = 8'h00;
  logic       ready = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  logic       inc4, valid4, last4, busy4, done4;
  logic [7:0] data4;
  logic       inc1, valid1, last1, busy1, done1;
  logic [7:0] data1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic flush_req = 1'b0;

  logic [7:0] acc4[$];
  logic       lst4[$];
  int done4_cnt = 0;
  logic [7:0] acc1[$];
  logic       lst1[$];
  int done1_cnt = 0;
  int acc1_cyc = 0;
  int done1_cyc = 0;
  int cyc = 0;
  int viol_empty = 0;
  int bp_viol = 0;
  int stab_viol = 0;
  int stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  frame_read_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .abort_i(abort), .trig_en_i(trig_en),
    .trig_level_i(level), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_inc_o(inc4), .out_data_o(data4), .out_valid_o(valid4), .out_ready_i(ready),
    .out_last_o(last4), .busy_o(busy4), .done_o(done4)
  );

  frame_read_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .arm_i(arm1), .abort_i(abort), .trig_en_i(trig_en),
    .trig_level_i(level), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_inc_o(inc1), .out_data_o(data1), .out_valid_o(valid1), .out_ready_i(ready),
    .out_last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush_req) rd_ptr <= wr_ptr;
    else if (inc4 || inc1) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    if ((inc4 || inc1) && fifo_empty) viol_empty <= viol_empty + 1;
    if (inc4 && valid4 && !ready) bp_viol <= bp_viol + 1;
    if (valid4 && !ready) stall_cnt <= stall_cnt + 1;
    if (prev_stall && data4 !== prev_data) stab_viol <= stab_viol + 1;
    prev_stall <= valid4 && !ready;
    prev_data  <= data4;
    if (valid4 && ready) begin
      acc4.push_back(data4);
      lst4.push_back(last4);
    end
    if (done4) done4_cnt <= done4_cnt + 1;
    if (valid1 && ready) begin
      acc1.push_back(data1);
      lst1.push_back(last1);
      acc1_cyc <= cyc;
    end
    if (done1) begin
      done1_cnt <= done1_cnt + 1;
      done1_cyc <= cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done4(input int base, input int budget, input string name);
    int n = 0;
    while (done4_cnt <= base && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (done4_cnt <= base) $display("FAIL %s_timeout: done count %0d, required > %0d", name, done4_cnt, base);
    else n_pass++;
  endtask

  task automatic check_frame(input int base, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input string name);
    logic [7:0] exp_d [4];
    logic [7:0] got;
    logic       gl;
    exp_d = '{e0, e1, e2, e3};
    n_checks++;
    if (acc4.size() - base !== 4) $display("FAIL %s_count: got %0d samples, required 4", name, acc4.size() - base);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (base + i < acc4.size()) ? acc4[base + i] : 8'hxx;
      gl  = (base + i < lst4.size()) ? lst4[base + i] : 1'bx;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL %s_data%0d: got %02h, required %02h", name, i, got, exp_d[i]);
      else n_pass++;
      n_checks++;
      if (gl !== (i == 3)) $display("FAIL %s_last%0d: got %b, required %b", name, i, gl, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    arm = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({valid4, last4, done4, busy4, inc4} !== 5'b0) $display("FAIL reset_flags: got %b, required 00000", {valid4, last4, done4, busy4, inc4});
    else n_pass++;
    n_checks++;
    if (data4 !== 8'h00) $display("FAIL reset_data: got %02h, required 00", data4);
    else n_pass++;
    n_checks++;
    if ({valid1, busy1, done1, inc1} !== 4'b0) $display("FAIL reset_len1: got %b, required 0000", {valid1, busy1, done1, inc1});
    else n_pass++;
    arm = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL reset_idle: busy got %b, required 0", busy4);
    else n_pass++;
  endtask

  task automatic test_level_trigger;
    int base = acc4.size();
    int dbase = done4_cnt;
    flush();
    push(8'h10); push(8'h70); push(8'h90); push(8'hA0); push(8'hB0); push(8'hC0); push(8'hD0);
    trig_en = 1'b1;
    level   = 8'h80;
    ready   = 1'b1;
    pulse_arm();
    wait_done4(dbase, 60, "trig");
    repeat (4) tick();
    check_frame(base, 8'h90, 8'hA0, 8'hB0, 8'hC0, "trig");
    n_checks++;
    if (done4_cnt - dbase !== 1) $display("FAIL trig_done: got %0d pulses, required 1", done4_cnt - dbase);
    else n_pass++;
    n_checks++;
    if (wr_ptr - rd_ptr !== 1 || fifo_data !== 8'hD0) $display("FAIL trig_left: got %0d words head %02h, required 1 word head d0", wr_ptr - rd_ptr, fifo_data);
    else n_pass++;
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL trig_idle: busy got %b, required 0", busy4);
    else n_pass++;
  endtask

  task automatic test_free_run;
    int base = acc4.size();
    int dbase = done4_cnt;
    flush();
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    trig_en = 1'b0;
    ready   = 1'b1;
    pulse_arm();
    wait_done4(dbase, 40, "free");
    repeat (2) tick();
    check_frame(base, 8'h05, 8'h06, 8'h07, 8'h08, "free");
    n_checks++;
    if (rd_ptr !== wr_ptr) $display("FAIL free_drain: got %0d words left, required 0", wr_ptr - rd_ptr);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int base = acc4.size();
    int dbase = done4_cnt;
    int sbase = stall_cnt;
    int n = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    flush();
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    trig_en = 1'b0;
    ready   = 1'b1;
    pulse_arm();
    while (done4_cnt <= dbase && n < 80) begin
      ready = pat[n % 4];
      tick();
      n++;
    end
    ready = 1'b1;
    n_checks++;
    if (done4_cnt <= dbase) $display("FAIL bp_timeout: done count %0d, required > %0d", done4_cnt, dbase);
    else n_pass++;
    repeat (2) tick();
    check_frame(base, 8'h21, 8'h22, 8'h23, 8'h24, "bp");
    n_checks++;
    if (stall_cnt == sbase) $display("FAIL bp_stalled: got %0d stall cycles, required > 0", stall_cnt - sbase);
    else n_pass++;
    n_checks++;
    if (bp_viol !== 0) $display("FAIL bp_pop: got %0d pops while stalled, required 0", bp_viol);
    else n_pass++;
    n_checks++;
    if (stab_viol !== 0) $display("FAIL bp_stable: got %0d data changes while stalled, required 0", stab_viol);
    else n_pass++;
  endtask

  task automatic test_underflow;
    int base = acc4.size();
    int dbase = done4_cnt;
    int n = 0;
    int gap_inc = 0;
    int gap_full = 0;
    flush();
    push(8'h31); push(8'h32);
    trig_en = 1'b0;
    ready   = 1'b1;
    pulse_arm();
    while (acc4.size() - base < 2 && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (inc4) gap_inc++;
      if (!fifo_empty) gap_full++;
    end
    n_checks++;
    if (gap_inc !== 0 || gap_full !== 0) $display("FAIL uf_gap: got %0d pops %0d non-empty, required 0 0", gap_inc, gap_full);
    else n_pass++;
    n_checks++;
    if (busy4 !== 1'b1 || done4_cnt !== dbase) $display("FAIL uf_hold: busy %b done %0d, required 1 %0d", busy4, done4_cnt, dbase);
    else n_pass++;
    tick();
    push(8'h33); push(8'h34);
    wait_done4(dbase, 40, "uf");
    repeat (2) tick();
    check_frame(base, 8'h31, 8'h32, 8'h33, 8'h34, "uf");
  endtask

  task automatic test_abort;
    int dbase = done4_cnt;
    int n = 0;
    int rd_before;
    flush();
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    trig_en = 1'b0;
    ready   = 1'b0;
    pulse_arm();
    while (!valid4 && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (valid4 !== 1'b1) $display("FAIL abort_setup: valid got %b, required 1", valid4);
    else n_pass++;
    rd_before = rd_ptr;
    abort = 1'b1;
    arm   = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inc4 !== 1'b0) $display("FAIL abort_nopop: inc got %b, required 0", inc4);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy4, valid4, last4, done4} !== 4'b0) $display("FAIL abort_idle: got %b, required 0000", {busy4, valid4, last4, done4});
    else n_pass++;
    abort = 1'b0;
    arm   = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy4 !== 1'b0 || done4_cnt !== dbase) $display("FAIL abort_arm: busy %b done %0d, required 0 %0d", busy4, done4_cnt, dbase);
    else n_pass++;
    n_checks++;
    if (rd_ptr !== rd_before) $display("FAIL abort_rd: got %0d pops, required 0", rd_ptr - rd_before);
    else n_pass++;
  endtask

  task automatic test_len1;
    int base = acc1.size();
    int dbase = done1_cnt;
    int n = 0;
    flush();
    push(8'h55);
    trig_en = 1'b0;
    ready   = 1'b1;
    arm1 = 1'b1;
    tick();
    arm1 = 1'b0;
    while (done1_cnt <= dbase && n < 20) begin
      tick();
      n++;
    end
    tick();
    n_checks++;
    if (acc1.size() - base !== 1 || acc1[acc1.size() - 1] !== 8'h55) $display("FAIL len1_data: got %0d samples, required one 55", acc1.size() - base);
    else n_pass++;
    n_checks++;
    if (lst1.size() == 0 || lst1[lst1.size() - 1] !== 1'b1) $display("FAIL len1_last: last flag not seen, required 1");
    else n_pass++;
    n_checks++;
    if (done1_cnt - dbase !== 1) $display("FAIL len1_done: got %0d pulses, required 1", done1_cnt - dbase);
    else n_pass++;
    n_checks++;
    if (done1_cyc - acc1_cyc !== 1) $display("FAIL len1_timing: done %0d cycles after accept, required 1", done1_cyc - acc1_cyc);
    else n_pass++;
  endtask

  task automatic test_no_empty_pop;
    n_checks++;
    if (viol_empty !== 0) $display("FAIL empty_pop: got %0d pops while empty, required 0", viol_empty);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_level_trigger();
    test_free_run();
    test_backpressure();
    test_underflow();
    test_abort();
    test_len1();
    test_no_empty_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
